// File: rtl/mycpu_pkg.sv
// Shared types and constants for the myCPU front end.
// IF_ADDR_EXC_EN adds the address-error flag to each fetch entry.
package mycpu_pkg;

   localparam int unsigned INST_W = 32;
   localparam int unsigned PC_W   = 32;

   localparam logic [PC_W-1:0] RESET_PC_DEFAULT   = 32'hBFC0_0000;
   localparam logic [PC_W-1:0] EXC_VECTOR_DEFAULT = 32'hBFC0_0380;

   typedef struct packed {
      logic [PC_W-1:0]   pc;
      logic [INST_W-1:0] inst;
`ifdef IF_ADDR_EXC_EN
      logic              adel;
`endif
   } fetch_entry_t;

endpackage

// File: rtl/fetch_stage_if.sv
// Fetch-stage bus bundle: instruction SRAM port, decode handshake and redirect inputs.
// IF_ADDR_EXC_EN adds the if_adel output.
interface fetch_stage_if #(
   parameter int unsigned ADDR_W = 32
);

   logic                          br_taken;
   logic [ADDR_W-1:0]             br_target;
   logic                          exc_valid;
   logic                          inst_sram_en;
   logic [ADDR_W-1:0]             inst_sram_addr;
   logic [mycpu_pkg::INST_W-1:0]  inst_sram_rdata;
   logic                          id_allowin;
   logic                          if_valid;
   logic [ADDR_W-1:0]             if_pc;
   logic [mycpu_pkg::INST_W-1:0]  if_inst;
`ifdef IF_ADDR_EXC_EN
   logic                          if_adel;
`endif

   modport master (
      input  br_taken, br_target, exc_valid, inst_sram_rdata, id_allowin,
      output inst_sram_en, inst_sram_addr, if_valid, if_pc, if_inst
`ifdef IF_ADDR_EXC_EN
      , output if_adel
`endif
   );

   modport slave (
      output br_taken, br_target, exc_valid, inst_sram_rdata, id_allowin,
      input  inst_sram_en, inst_sram_addr, if_valid, if_pc, if_inst
`ifdef IF_ADDR_EXC_EN
      , input if_adel
`endif
   );

endinterface

// File: rtl/fetch_buffer.sv
// Synchronous FIFO of fetch entries. flush wins over push; DEPTH must be a power of 2, >= 2.
module fetch_buffer
   import mycpu_pkg::*;
#(
   parameter int unsigned DEPTH = 2
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic                         push,
   input  fetch_entry_t                 push_data,
   input  logic                         pop,
   input  logic                         flush,
   output logic [$clog2(DEPTH+1)-1:0]   count,
   output fetch_entry_t                 head
);

   localparam int unsigned PtrW = $clog2(DEPTH);
   localparam int unsigned CntW = $clog2(DEPTH + 1);

   fetch_entry_t    mem_q [DEPTH];
   logic [PtrW-1:0] rd_ptr_q, wr_ptr_q;
   logic [CntW-1:0] count_q;

   always_ff @(posedge clk) begin
      if (rst || flush) begin
         rd_ptr_q <= '0;
         wr_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         if (push) wr_ptr_q <= wr_ptr_q + PtrW'(1);
         if (pop)  rd_ptr_q <= rd_ptr_q + PtrW'(1);
         count_q <= count_q + CntW'(push) - CntW'(pop);
      end
   end

   // Storage needs no reset; count gates everything that reads it.
   always_ff @(posedge clk) begin
      if (push && !flush && !rst) mem_q[wr_ptr_q] <= push_data;
   end

   assign count = count_q;
   assign head  = mem_q[rd_ptr_q];

   assert property (@(posedge clk) disable iff (rst)
      !(push && !flush && !pop && (count_q == CntW'(DEPTH))));
   assert property (@(posedge clk) disable iff (rst) !(pop && (count_q == '0)));

endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch: PC, single-request SRAM issue, redirect/flush control, buffered output.
// IF_ADDR_EXC_EN turns misaligned PCs into address-error entries and stalls fetch.
module fetch_stage
   import mycpu_pkg::*;
#(
   parameter int unsigned       ADDR_W     = 32,
   parameter logic [ADDR_W-1:0] RESET_PC   = ADDR_W'(RESET_PC_DEFAULT),
   parameter logic [ADDR_W-1:0] EXC_VECTOR = ADDR_W'(EXC_VECTOR_DEFAULT),
   parameter int unsigned       BUF_DEPTH  = 2
) (
   input logic           clk,
   input logic           rst,
   fetch_stage_if.master fif
);

   localparam int unsigned CntW = $clog2(BUF_DEPTH + 1);

   logic [ADDR_W-1:0] pc_q, pc_d;
   logic [ADDR_W-1:0] req_pc_q, req_pc_d;
   logic              inflight_q, inflight_d;
   logic              discard_q, discard_d;
   logic              req_adel_q, req_adel_d;
   logic              stall_q, stall_d;

   logic              redirect, space, can_issue, adel_issue;
   logic              push, pop, if_valid;
   logic [CntW-1:0]   count;
   int unsigned       occupancy;
   fetch_entry_t      head, push_entry;

   always_comb begin
      redirect  = fif.exc_valid | fif.br_taken;
      if_valid  = !rst && (count != '0);
      pop       = if_valid & fif.id_allowin;
      // Slots already claimed once this cycle's pop is accounted for.
      occupancy = 32'(count) + 32'(inflight_q) - 32'(pop);
      space     = occupancy < BUF_DEPTH;
      can_issue = !rst & !redirect & space & !stall_q;
`ifdef IF_ADDR_EXC_EN
      adel_issue = can_issue & (pc_q[1:0] != 2'b00);
`else
      adel_issue = 1'b0;
`endif
   end

   always_comb begin
      pc_d       = pc_q;
      req_pc_d   = req_pc_q;
      inflight_d = can_issue;
      req_adel_d = adel_issue;
      discard_d  = redirect & inflight_q;
      stall_d    = stall_q;
      if (redirect) begin
         pc_d    = fif.exc_valid ? EXC_VECTOR : fif.br_target;
         stall_d = 1'b0;
      end else if (adel_issue) begin
         req_pc_d = pc_q;
         stall_d  = 1'b1;
      end else if (can_issue) begin
         req_pc_d = pc_q;
         pc_d     = pc_q + ADDR_W'(4);
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         pc_q       <= RESET_PC;
         req_pc_q   <= RESET_PC;
         inflight_q <= 1'b0;
         discard_q  <= 1'b0;
         req_adel_q <= 1'b0;
         stall_q    <= 1'b0;
      end else begin
         pc_q       <= pc_d;
         req_pc_q   <= req_pc_d;
         inflight_q <= inflight_d;
         discard_q  <= discard_d;
         req_adel_q <= req_adel_d;
         stall_q    <= stall_d;
      end
   end

   always_comb begin
      push            = inflight_q & !discard_q;
      push_entry      = '0;
      push_entry.pc   = PC_W'(req_pc_q);
      push_entry.inst = req_adel_q ? '0 : fif.inst_sram_rdata;
`ifdef IF_ADDR_EXC_EN
      push_entry.adel = req_adel_q;
`endif
   end

   fetch_buffer #(
      .DEPTH (BUF_DEPTH)
   ) u_buf (
      .clk       (clk),
      .rst       (rst),
      .push      (push),
      .push_data (push_entry),
      .pop       (pop),
      .flush     (redirect),
      .count     (count),
      .head      (head)
   );

   assign fif.inst_sram_en   = can_issue & !adel_issue;
   assign fif.inst_sram_addr = pc_q;
   assign fif.if_valid       = if_valid;
   assign fif.if_pc          = head.pc[ADDR_W-1:0];
   assign fif.if_inst        = head.inst;
`ifdef IF_ADDR_EXC_EN
   assign fif.if_adel        = head.adel;
`endif

endmodule

// File: tb/tb_fetch_stage.sv
// Scoreboard bench for fetch_stage: stimulus queues expected entries, a monitor checks each pop.
module tb_fetch_stage;
   import mycpu_pkg::*;

   localparam int unsigned ADDR_W    = 32;
   localparam int unsigned BUF_DEPTH = 2;

   typedef struct {
      logic [31:0] pc;
      logic [31:0] inst;
      logic        adel;
   } exp_t;

   logic clk;
   logic rst;
   exp_t sb[$];
   int   n_tests = 0;
   int   n_fail  = 0;

   fetch_stage_if #(.ADDR_W(ADDR_W)) fif ();

   fetch_stage #(
      .ADDR_W     (ADDR_W),
      .RESET_PC   (32'hBFC0_0000),
      .EXC_VECTOR (32'hBFC0_0380),
      .BUF_DEPTH  (BUF_DEPTH)
   ) dut (
      .clk (clk),
      .rst (rst),
      .fif (fif.master)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [31:0] sram_fn(input logic [31:0] a);
      return {a[15:0], ~a[15:0]};
   endfunction

   // One-cycle-latency SRAM model.
   always @(posedge clk) begin
      fif.inst_sram_rdata <= fif.inst_sram_en ? sram_fn(fif.inst_sram_addr) : 32'h0BAD_0BAD;
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h, expected %h", name, act, exp);
      end
   endtask

   always @(negedge clk) begin : monitor
      exp_t e;
      if (fif.if_valid === 1'b1 && fif.id_allowin === 1'b1) begin
         if (sb.size() == 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL unexpected_pop: got pc %h, expected no entry", fif.if_pc);
         end else begin
            e = sb.pop_front();
            check("pop_pc", fif.if_pc, e.pc);
            check("pop_inst", fif.if_inst, e.inst);
`ifdef IF_ADDR_EXC_EN
            check("pop_adel", 32'(fif.if_adel), 32'(e.adel));
`endif
         end
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic look();
      #2;
   endtask

   task automatic expect_seq(input logic [31:0] start, input int n);
      for (int i = 0; i < n; i++) begin
         exp_t e;
         e.pc   = start + 32'(4 * i);
         e.inst = sram_fn(e.pc);
         e.adel = 1'b0;
         sb.push_back(e);
      end
   endtask

   // Leaves the bench at cycle 1 after reset release (1 ns past the edge).
   task automatic do_reset(input logic allow);
      rst            = 1'b1;
      fif.br_taken   = 1'b0;
      fif.br_target  = '0;
      fif.exc_valid  = 1'b0;
      fif.id_allowin = allow;
      step();
      look();
      check("rst_en", 32'(fif.inst_sram_en), 32'd0);
      check("rst_valid", 32'(fif.if_valid), 32'd0);
      step();
      step();
      rst = 1'b0;
   endtask

   task automatic drain();
      int budget = 40;
      fif.id_allowin = 1'b1;
      while (sb.size() != 0 && budget > 0) begin
         step();
         budget--;
      end
      fif.id_allowin = 1'b0;
      check("drain_left", 32'(sb.size()), 32'd0);
   endtask

   initial begin : watchdog
      #200000;
      $display("FAIL watchdog: got timeout, expected $finish");
      $fatal(1, "timeout");
   end

   initial begin : stim
      int n_req;
      fif.inst_sram_rdata = '0;

      // 1: reset release with decode always ready
      expect_seq(32'hBFC0_0000, 6);
      do_reset(1'b1);
      look();
      check("t1_en_c1", 32'(fif.inst_sram_en), 32'd1);
      check("t1_addr_c1", fif.inst_sram_addr, 32'hBFC0_0000);
      step();
      look();
      check("t1_addr_c2", fif.inst_sram_addr, 32'hBFC0_0004);
      check("t1_valid_c2", 32'(fif.if_valid), 32'd0);
      step();
      look();
      check("t1_valid_c3", 32'(fif.if_valid), 32'd1);
      check("t1_pc_c3", fif.if_pc, 32'hBFC0_0000);
      drain();

      // 2: decode stalled from reset, buffer fills, then drains in order
      do_reset(1'b0);
      n_req = 0;
      for (int i = 0; i < 6; i++) begin
         look();
         if (fif.inst_sram_en === 1'b1) n_req++;
         step();
      end
      check("t2_nreq", 32'(n_req), 32'(BUF_DEPTH));
      look();
      check("t2_en_full", 32'(fif.inst_sram_en), 32'd0);
      expect_seq(32'hBFC0_0000, 5);
      drain();

      // 3: branch with a request in flight
      do_reset(1'b0);
      look();
      check("t3_addr_c1", fif.inst_sram_addr, 32'hBFC0_0000);
      step();
      fif.br_taken  = 1'b1;
      fif.br_target = 32'hBFC0_0100;
      look();
      check("t3_en_redir", 32'(fif.inst_sram_en), 32'd0);
      step();
      fif.br_taken = 1'b0;
      look();
      check("t3_valid_drop", 32'(fif.if_valid), 32'd0);
      check("t3_en_tgt", 32'(fif.inst_sram_en), 32'd1);
      check("t3_addr_tgt", fif.inst_sram_addr, 32'hBFC0_0100);
      expect_seq(32'hBFC0_0100, 3);
      drain();

      // 4: exception beats branch
      do_reset(1'b0);
      fif.exc_valid = 1'b1;
      fif.br_taken  = 1'b1;
      fif.br_target = 32'hBFC0_0100;
      look();
      check("t4_en_redir", 32'(fif.inst_sram_en), 32'd0);
      step();
      fif.exc_valid = 1'b0;
      fif.br_taken  = 1'b0;
      look();
      check("t4_en", 32'(fif.inst_sram_en), 32'd1);
      check("t4_addr", fif.inst_sram_addr, 32'hBFC0_0380);
      expect_seq(32'hBFC0_0380, 2);
      drain();

      // 5: reset pulse with a full buffer
      do_reset(1'b0);
      repeat (5) step();
      look();
      check("t5_valid_full", 32'(fif.if_valid), 32'd1);
      rst = 1'b1;
      look();
      check("t5_valid_in_rst", 32'(fif.if_valid), 32'd0);
      check("t5_en_in_rst", 32'(fif.inst_sram_en), 32'd0);
      step();
      rst = 1'b0;
      look();
      check("t5_valid_after", 32'(fif.if_valid), 32'd0);
      check("t5_addr_after", fif.inst_sram_addr, 32'hBFC0_0000);
      check("t5_en_after", 32'(fif.inst_sram_en), 32'd1);
      expect_seq(32'hBFC0_0000, 2);
      drain();

`ifdef IF_ADDR_EXC_EN
      // 6: misaligned target yields an address-error entry and stalls fetch
      begin
         exp_t e;
         do_reset(1'b0);
         fif.br_taken  = 1'b1;
         fif.br_target = 32'hBFC0_0102;
         step();
         fif.br_taken = 1'b0;
         look();
         check("t6_en_mis", 32'(fif.inst_sram_en), 32'd0);
         step();
         step();
         look();
         check("t6_valid", 32'(fif.if_valid), 32'd1);
         check("t6_pc", fif.if_pc, 32'hBFC0_0102);
         check("t6_adel", 32'(fif.if_adel), 32'd1);
         check("t6_inst", fif.if_inst, 32'h0);
         check("t6_en_stall", 32'(fif.inst_sram_en), 32'd0);
         e.pc   = 32'hBFC0_0102;
         e.inst = 32'h0;
         e.adel = 1'b1;
         sb.push_back(e);
         drain();
         step();
         look();
         check("t6_en_stall2", 32'(fif.inst_sram_en), 32'd0);
         fif.exc_valid = 1'b1;
         step();
         fif.exc_valid = 1'b0;
         look();
         check("t6_en_exc", 32'(fif.inst_sram_en), 32'd1);
         check("t6_addr_exc", fif.inst_sram_addr, 32'hBFC0_0380);
      end
`endif

      step();
      check("sb_empty", 32'(sb.size()), 32'd0);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
